decoder_n_sweep: RTL and testbench

DECODER_N_SWEEP -- requirements
Module: decoder_n_sweep

---
 rtl/decoder_n_sweep_pkg.sv | 12 +
 rtl/decoder_n_sweep_if.sv | 23 ++
 rtl/decoder_n_sweep_onehot.sv | 15 +
 rtl/decoder_n_sweep.sv | 82 ++++++++
 tb/tb_decoder_n_sweep.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_n_sweep_pkg.sv
// Shared types and limits for the one-hot decoder with automatic sweep.
package decoder_pkg;

  localparam int MAX_N = 6;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

endpackage

// File: rtl/decoder_n_sweep_if.sv
// Request/response bundle of the sweep decoder; the decoder sits on the slave side.
interface decoder_n_sweep_if #(
  parameter int N = 3
) ();

  logic             enable;
  logic [N-1:0]     addr;
  logic             sweep_start;
  logic [2**N-1:0]  y;
  logic             busy;
  logic             done;

  modport master (
    output enable, addr, sweep_start,
    input  y, busy, done
  );

  modport slave (
    input  enable, addr, sweep_start,
    output y, busy, done
  );

endinterface

// File: rtl/decoder_n_sweep_onehot.sv
// Combinational N-to-2**N one-hot decoder; all-zero when en is low.
module decoder_onehot #(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [2**N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_n_sweep.sv
// Registered one-hot decoder that can also step its output through every index once.
module decoder_n_sweep
  import decoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              reset,
  decoder_n_sweep_if.slave  bus
);

  localparam int W = 2**N;
  localparam logic [N-1:0] LAST = {N{1'b1}};

  state_t         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   sel;
  logic           en;
  logic [W-1:0]   oh;
  logic [W-1:0]   y_q;

  // cnt_q always holds the index currently shown on y while sweeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel     = bus.addr;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sweep_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
          sel     = '0;
          en      = 1'b1;
        end else begin
          en = bus.enable;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + N'(1);
          sel   = cnt_q + N'(1);
          en    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  decoder_onehot #(.N(N)) u_onehot (
    .sel    (sel),
    .en     (en),
    .onehot (oh)
  );

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= oh;
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = (state_q == SWEEP);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_decoder_n_sweep.sv
// Directed bench for decoder_n_sweep at N=3, with N=1 and N=6 instances for sweep length.
module tb_decoder_n_sweep;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  decoder_n_sweep_if #(.N(3)) if3 ();
  decoder_n_sweep_if #(.N(1)) if1 ();
  decoder_n_sweep_if #(.N(6)) if6 ();

  decoder_n_sweep #(.N(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
  decoder_n_sweep #(.N(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  decoder_n_sweep #(.N(6)) dut6 (.clk(clk), .reset(reset), .bus(if6));

  logic [7:0] oh3 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  // Every-cycle invariants on all three instances
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(if3.y) || !$onehot0(if1.y) || !$onehot0(if6.y)) begin
        failures++;
        $display("FAIL onehot: y3=%h y1=%h y6=%h, required at most one bit set", if3.y, if1.y, if6.y);
      end
      checks++;
      if ((if3.busy && if3.done) || (if1.busy && if1.done) || (if6.busy && if6.done)) begin
        failures++;
        $display("FAIL busy_done_excl: busy/done both high (n3 %b%b n1 %b%b n6 %b%b), required exclusive",
                 if3.busy, if3.done, if1.busy, if1.done, if6.busy, if6.done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if3.enable = 1'b0; if3.addr = '0; if3.sweep_start = 1'b0;
    if1.enable = 1'b0; if1.addr = '0; if1.sweep_start = 1'b0;
    if6.enable = 1'b0; if6.addr = '0; if6.sweep_start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    if3.enable = 1'b1;
    if3.addr   = 3'd5;
    reset = 1'b1;
    step();
    step();
    checks++;
    if (if3.y !== 8'h00 || if3.busy !== 1'b0 || if3.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_n3: y=%h busy=%b done=%b, required y=00 busy=0 done=0", if3.y, if3.busy, if3.done);
    end
    checks++;
    if (if1.y !== 2'b00 || if6.y !== 64'd0 || if1.busy !== 1'b0 || if6.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wide: y1=%h y6=%h busy1=%b busy6=%b, required zeros", if1.y, if6.y, if1.busy, if6.busy);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    if3.addr = 3'd2;
    step();
    checks++;
    if (if3.y !== 8'h04 || if3.busy !== 1'b0) begin
      failures++;
      $display("FAIL first_after_reset: y=%h busy=%b, required y=04 busy=0", if3.y, if3.busy);
    end
  endtask

  task automatic test_decode();
    if3.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if3.addr = 3'(i);
      step();
      checks++;
      if (if3.y !== oh3[i] || if3.busy !== 1'b0 || if3.done !== 1'b0) begin
        failures++;
        $display("FAIL decode addr=%0d: y=%h busy=%b done=%b, required y=%h busy=0 done=0",
                 i, if3.y, if3.busy, if3.done, oh3[i]);
      end
    end
  endtask

  task automatic test_disabled();
    if3.enable = 1'b0;
    if3.addr   = 3'd5;
    step();
    checks++;
    if (if3.y !== 8'h00 || if3.busy !== 1'b0 || if3.done !== 1'b0) begin
      failures++;
      $display("FAIL disabled: y=%h busy=%b done=%b, required y=00 busy=0 done=0", if3.y, if3.busy, if3.done);
    end
  endtask

  task automatic test_sweep_ignores_inputs();
    if3.sweep_start = 1'b1;
    step();
    if3.sweep_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (if3.y !== oh3[i] || if3.busy !== 1'b1 || if3.done !== 1'b0) begin
        failures++;
        $display("FAIL sweep count=%0d: y=%h busy=%b done=%b, required y=%h busy=1 done=0",
                 i, if3.y, if3.busy, if3.done, oh3[i]);
      end
      if3.enable      = 1'b1;
      if3.addr        = 3'(7 - i);
      if3.sweep_start = (i == 3);
      step();
    end
    checks++;
    if (if3.y !== 8'h00 || if3.busy !== 1'b0 || if3.done !== 1'b1) begin
      failures++;
      $display("FAIL sweep_done: y=%h busy=%b done=%b, required y=00 busy=0 done=1", if3.y, if3.busy, if3.done);
    end
    if3.enable      = 1'b0;
    if3.sweep_start = 1'b1;
    step();
    checks++;
    if (if3.y !== 8'h00 || if3.busy !== 1'b0 || if3.done !== 1'b0) begin
      failures++;
      $display("FAIL after_done_idle: y=%h busy=%b done=%b, required y=00 busy=0 done=0", if3.y, if3.busy, if3.done);
    end
    if3.sweep_start = 1'b0;
    step();
    checks++;
    if (if3.y !== 8'h00 || if3.busy !== 1'b0) begin
      failures++;
      $display("FAIL no_queued_sweep: y=%h busy=%b, required y=00 busy=0", if3.y, if3.busy);
    end
  endtask

  task automatic test_priority();
    if3.enable      = 1'b1;
    if3.addr        = 3'd6;
    if3.sweep_start = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (if3.y !== 8'h01 || if3.busy !== 1'b1) begin
      failures++;
      $display("FAIL start_priority: y=%h busy=%b, required y=01 busy=1", if3.y, if3.busy);
    end
    repeat (7) step();
    checks++;
    if (if3.y !== 8'h80 || if3.busy !== 1'b1) begin
      failures++;
      $display("FAIL priority_last: y=%h busy=%b, required y=80 busy=1", if3.y, if3.busy);
    end
    step();
    checks++;
    if (if3.done !== 1'b1 || if3.y !== 8'h00) begin
      failures++;
      $display("FAIL priority_done: y=%h done=%b, required y=00 done=1", if3.y, if3.done);
    end
    step();
  endtask

  task automatic test_reset_mid_sweep();
    if3.sweep_start = 1'b1;
    step();
    if3.sweep_start = 1'b0;
    repeat (4) step();
    checks++;
    if (if3.y !== 8'h10 || if3.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_sweep_count4: y=%h busy=%b, required y=10 busy=1", if3.y, if3.busy);
    end
    reset = 1'b1;
    step();
    checks++;
    if (if3.y !== 8'h00 || if3.busy !== 1'b0 || if3.done !== 1'b0) begin
      failures++;
      $display("FAIL mid_sweep_reset: y=%h busy=%b done=%b, required y=00 busy=0 done=0", if3.y, if3.busy, if3.done);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (if3.done !== 1'b0 || if3.busy !== 1'b0) begin
        failures++;
        $display("FAIL aborted_no_done cycle=%0d: busy=%b done=%b, required busy=0 done=0", i, if3.busy, if3.done);
      end
    end
  endtask

  task automatic test_held_start();
    if3.sweep_start = 1'b1;
    step();
    repeat (7) step();
    checks++;
    if (if3.y !== 8'h80 || if3.busy !== 1'b1) begin
      failures++;
      $display("FAIL held_last: y=%h busy=%b, required y=80 busy=1", if3.y, if3.busy);
    end
    step();
    checks++;
    if (if3.done !== 1'b1 || if3.busy !== 1'b0) begin
      failures++;
      $display("FAIL held_done: busy=%b done=%b, required busy=0 done=1", if3.busy, if3.done);
    end
    step();
    checks++;
    if (if3.y !== 8'h00 || if3.busy !== 1'b0 || if3.done !== 1'b0) begin
      failures++;
      $display("FAIL held_idle: y=%h busy=%b done=%b, required y=00 busy=0 done=0", if3.y, if3.busy, if3.done);
    end
    step();
    checks++;
    if (if3.y !== 8'h01 || if3.busy !== 1'b1) begin
      failures++;
      $display("FAIL held_restart: y=%h busy=%b, required y=01 busy=1", if3.y, if3.busy);
    end
    if3.sweep_start = 1'b0;
    repeat (8) step();
    checks++;
    if (if3.done !== 1'b1) begin
      failures++;
      $display("FAIL held_second_done: done=%b, required 1", if3.done);
    end
    step();
  endtask

  task automatic test_wide_sweeps();
    int n1 = 0, n6 = 0, d1 = 0, d6 = 0;
    logic [1:0]  e1;
    logic [63:0] e6;
    if1.sweep_start = 1'b1;
    if6.sweep_start = 1'b1;
    step();
    if1.sweep_start = 1'b0;
    if6.sweep_start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (if1.busy) begin
        e1 = 2'b01 << n1;
        checks++;
        if (if1.y !== e1) begin
          failures++;
          $display("FAIL n1_sweep count=%0d: y=%h, required %h", n1, if1.y, e1);
        end
        n1++;
      end
      if (if6.busy) begin
        e6 = 64'd1 << n6;
        checks++;
        if (if6.y !== e6) begin
          failures++;
          $display("FAIL n6_sweep count=%0d: y=%h, required %h", n6, if6.y, e6);
        end
        n6++;
      end
      if (if1.done) d1++;
      if (if6.done) d6++;
      step();
    end
    checks++;
    if (n1 != 2 || d1 != 1) begin
      failures++;
      $display("FAIL n1_length: busy_cycles=%0d done_pulses=%0d, required 2 and 1", n1, d1);
    end
    checks++;
    if (n6 != 64 || d6 != 1) begin
      failures++;
      $display("FAIL n6_length: busy_cycles=%0d done_pulses=%0d, required 64 and 1", n6, d6);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_decode();
    test_disabled();
    test_sweep_ignores_inputs();
    test_priority();
    test_reset_mid_sweep();
    test_held_start();
    test_wide_sweeps();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
